rx_byte_fifo: RTL
=================

# rx_byte_fifo

Receive-side byte buffer that sits directly downstream of the UART receiver. It converts the receiver's level-style valid (held high from stop bit until the next start bit) into single-byte pushes. It stores up to DEPTH bytes and presents them to the consumer through a read-enable handshake, with occupancy status and a sticky overflow flag. It runs on the same oversample clock as the receiver.

## Interface
- DEPTH, 16, number of byte entries; power of two, ≥ 2; AW = log2(DEPTH) is derived internally.
- clk  input  1  oversample clock, shared with the receiver.
- rst  input  1  synchronous, active-high reset.
- rx_valid  input  1  receiver valid level; falls at start bit, rises once per received byte.
- rx_data  input  8  received byte; stable while rx_valid is high.
- rd_en  input  1  consumer pop request.
- ovf_clr  input  1  clears the overflow flag.
- dout  output  8  head byte (FWFT) or last popped byte (registered mode).
- dout_valid  output  1  dout holds a valid byte (meaning depends on mode; see Configuration).
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  AW+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; a byte was dropped because the FIFO was full.

## Operation
- Push detect: register rx_valid_q; push = rx_valid & ~rx_valid_q.
  - Exactly one push per rising edge of rx_valid, regardless of how long rx_valid stays high.
- Storage: DEPTH×8 array, write pointer wr_ptr and read pointer rd_ptr.
  - Both pointers are AW bits and wrap from DEPTH-1 to 0 with no special casing.
- Pop: pop = rd_en & ~empty. rd_en while empty is ignored; no state changes.
- Push accepted when ~full, or when full and pop in the same cycle.
  - Accepted push: write rx_data at wr_ptr, then increment wr_ptr.
- Push while full with no pop: byte dropped, pointers unchanged, overflow ← 1.
- count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Simultaneous push and pop at count==0: the pop is ignored (empty) and the push is accepted, so count becomes 1.
- Simultaneous push and pop at count==DEPTH: both are performed and count stays DEPTH.
- overflow is cleared by ovf_clr. If ovf_clr coincides with a new drop, the set wins and overflow stays 1.
- No state machine beyond the pointer/count datapath. Control is the push/pop decode above.

## Timing
- Reset values (all registers are synchronous on clk):
  - wr_ptr = rd_ptr = 0, count = 0, empty = 1, full = 0, overflow = 0, dout = 8'h00, dout_valid = 0.
  - rx_valid_q = 1, so an rx_valid already high out of reset does not create a phantom push.
- Reset mid-operation discards all stored bytes. A byte whose rx_valid rose during reset is not pushed.
- Push latency: when rx_valid is first sampled high at edge k, the array, count, empty and full update at edge k.
- full, empty and count are registered, or decoded from registered count, with no combinational path from rd_en or rx_valid.

## Configuration
- RX_FIFO_FWFT_EN defined (first-word fall-through):
  - dout = array[rd_ptr], combinational from registered state.
  - dout_valid = ~empty.
  - The byte pushed at edge k appears on dout in the cycle after k.
  - rd_en acknowledges the byte currently shown on dout.
- RX_FIFO_FWFT_EN undefined (registered read):
  - Pop at edge k loads dout ← array[rd_ptr] at edge k.
  - dout_valid is high for exactly the one cycle after k, and is 0 otherwise.
  - dout holds its value until the next pop.
  - Back-to-back rd_en gives one byte per cycle.
- count, full, empty and overflow behave identically in both modes.

## Test plan
- Reset with rx_valid held high, no further edges → count stays 0, empty=1, no push.
- rx_valid pulses low then high with rx_data 8'hA5, then 8'h3C; rx_valid held high for 20 cycles each → count=2.
  - FWFT: dout=8'hA5 before any read.
  - Registered mode: two rd_en cycles give dout 8'hA5 then 8'h3C, each with a 1-cycle dout_valid.
- DEPTH=16: 17 bytes pushed with no reads → full=1, count=16, overflow=1.
  - Popping all entries returns bytes 1..16 in order; byte 17 is lost.
  - ovf_clr → overflow=0.
- Full FIFO with push and rd_en in the same cycle → count stays 16, overflow stays 0.
  - The new byte is read out last.
- Wrap-around: push/pop 40 bytes 8'h00..8'h27 while occupancy stays ≤3 → exact order preserved across pointer wrap; empty=1 at the end.
- rst asserted with 5 bytes stored and rd_en high → next cycle count=0, empty=1, dout=0, dout_valid=0, overflow=0.

Source files
------------

// File: rtl/rx_byte_fifo.sv
// rtl/rx_byte_fifo.sv - UART receive byte FIFO with edge-detected push, sticky overflow, optional FWFT read (RX_FIFO_FWFT_EN)
module rx_byte_fifo #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    input  logic          rd_en,
    input  logic          ovf_clr,
    output logic [7:0]    dout,
    output logic          dout_valid,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          rx_valid_q;
    logic          push;
    logic          pop;
    logic          accept;
    logic          drop;

    // The receiver holds valid as a level; only its rising edge is a new byte.
    assign push   = rx_valid & ~rx_valid_q;
    assign pop    = rd_en & ~empty;
    // A full FIFO still takes a byte when a slot frees up in the same cycle.
    assign accept = push & (~full | pop);
    assign drop   = push & full & ~pop;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // Edge detector, pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_valid_q <= 1'b1;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
        end else begin
            rx_valid_q <= rx_valid;
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // Byte storage; cleared on reset so a fall-through head reads zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (accept) begin
            mem[wr_ptr] <= rx_data;
        end
    end

`ifdef RX_FIFO_FWFT_EN
    assign dout       = mem[rd_ptr];
    assign dout_valid = ~empty;
`else
    // Registered read: a pop loads the head byte and flags it for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout       <= 8'h00;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= pop;
            if (pop) begin
                dout <= mem[rd_ptr];
            end
        end
    end
`endif

endmodule
